// File: rtl/rtx_fb_writer_pkg.sv
// rtl/rtx_fb_writer_pkg.sv - shared types and constants for the framebuffer writer
//
// Purpose: FIFO entry layout, writer state encoding and default frame geometry.
// The entry offset field is sized for the default 1280x720 frame. Smaller
// frames zero-extend into it, so WIDTH*HEIGHT must not exceed FB_PIXELS.
package rtx_fb_writer_pkg;

  localparam int FB_WIDTH      = 1280;
  localparam int FB_HEIGHT     = 720;
  localparam int FB_PIXELS     = FB_WIDTH * FB_HEIGHT;
  localparam int FB_PIX_ADDR_W = $clog2(FB_PIXELS);
  localparam int FB_ADDR_W     = FB_PIX_ADDR_W + 1;

  typedef struct packed {
    logic [FB_PIX_ADDR_W-1:0] offset;
    logic [15:0]              pixel;
  } fb_entry_t;

  typedef enum logic {
    FB_WRITE,
    FB_WAIT_SWAP
  } fb_state_t;

endpackage

// File: rtl/rtx_fb_writer_fifo.sv
// rtl/rtx_fb_writer_fifo.sv - synchronous show-ahead FIFO with registered output
//
// Purpose: generic FIFO. DEPTH entries in total; dout always presents the head
// entry from a register whenever empty is low.
// Ports:
//   clk, rst     clock, synchronous active-high reset (flushes contents)
//   push, din    write request and data; accepted when not full, or when full
//                with a pop in the same cycle
//   full         DEPTH entries held
//   pop          remove head (ignored when empty)
//   dout, empty  registered head entry and empty flag
module pixel_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic         full,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          do_push, do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_comb begin
    do_pop     = pop && !empty;
    do_push    = push && (!full || do_pop);
    rd_ptr_nxt = rd_ptr + PW'(do_pop);
    count_nxt  = count + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(do_push);
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      // A push into a FIFO that is (or becomes) empty bypasses the array so
      // the new head is visible the next cycle.
      if (do_push && (count - CW'(do_pop)) == '0)
        dout <= din;
      else if (count_nxt != '0)
        dout <= mem[rd_ptr_nxt];
    end
  end

endmodule

// File: rtl/rtx_fb_writer.sv
// rtl/rtx_fb_writer.sv - ray tracer pixel sink into a double-buffered framebuffer
//
// Purpose: address each finished pixel, queue it, write it through a
// valid/ready port, count the frame and swap buffers on display vsync.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   rtx_pixel, pixel_h, pixel_v   RGB565 pixel and its column/row
//   ray_done                      one-cycle strobe qualifying the pixel inputs
//   fb_addr, fb_data, fb_wvalid   write request {buf_sel, offset}, pixel
//   fb_wready                     memory accepts when fb_wvalid && fb_wready
//   frame_sync                    display vsync pulse
//   display_buf                   buffer being displayed (~buf_sel)
//   frame_done                    pulse after the last pixel of a frame
//   overflow, bad_coord           sticky drop flags
module rtx_fb_writer
  import rtx_fb_writer_pkg::*;
#(
  parameter int WIDTH      = FB_WIDTH,
  parameter int HEIGHT     = FB_HEIGHT,
  parameter int FIFO_DEPTH = 8,
  parameter int PIX_ADDR_W = $clog2(WIDTH * HEIGHT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         rtx_pixel,
  input  logic [10:0]         pixel_h,
  input  logic [9:0]          pixel_v,
  input  logic                ray_done,
  output logic [PIX_ADDR_W:0] fb_addr,
  output logic [15:0]         fb_data,
  output logic                fb_wvalid,
  input  logic                fb_wready,
  input  logic                frame_sync,
  output logic                display_buf,
  output logic                frame_done,
  output logic                overflow,
  output logic                bad_coord
);

  localparam int PIXELS = WIDTH * HEIGHT;
  localparam int CNT_W  = $clog2(PIXELS + 1);

  logic                  in_range;
  logic [PIX_ADDR_W-1:0] offset;
  logic                  s1_valid;
  fb_entry_t             s1_entry;
  fb_entry_t             head;
  logic                  fifo_full, fifo_empty, wr_fire;
  fb_state_t             state;
  logic                  buf_sel;
  logic [CNT_W-1:0]      pix_count;

  // WIDTH is a constant, so the multiply reduces to shifts and adds.
  always_comb begin
    in_range = (32'(pixel_h) < 32'(WIDTH)) && (32'(pixel_v) < 32'(HEIGHT));
    offset   = PIX_ADDR_W'(32'(pixel_v) * 32'(WIDTH) + 32'(pixel_h));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_entry  <= '0;
      bad_coord <= 1'b0;
    end else begin
      s1_valid <= ray_done && in_range;
      if (ray_done && in_range) begin
        s1_entry.offset <= FB_PIX_ADDR_W'(offset);
        s1_entry.pixel  <= rtx_pixel;
      end
      if (ray_done && !in_range) bad_coord <= 1'b1;
    end
  end

  pixel_fifo #(
    .W     ($bits(fb_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s1_valid),
    .din   (s1_entry),
    .full  (fifo_full),
    .pop   (wr_fire),
    .dout  (head),
    .empty (fifo_empty)
  );

  assign fb_wvalid   = (state == FB_WRITE) && !fifo_empty;
  assign wr_fire     = fb_wvalid && fb_wready;
  assign fb_addr     = {buf_sel, head.offset[PIX_ADDR_W-1:0]};
  assign fb_data     = head.pixel;
  assign display_buf = ~buf_sel;

  always_ff @(posedge clk) begin
    if (rst) overflow <= 1'b0;
    else if (s1_valid && fifo_full && !wr_fire) overflow <= 1'b1;
  end

  // frame_sync is only looked at in WAIT_SWAP, so a vsync landing on the
  // final handshake is ignored and the swap waits for the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FB_WRITE;
      buf_sel    <= 1'b0;
      pix_count  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state == FB_WRITE) begin
        if (wr_fire) begin
          if (pix_count == CNT_W'(PIXELS - 1)) begin
            pix_count  <= '0;
            frame_done <= 1'b1;
            state      <= FB_WAIT_SWAP;
          end else begin
            pix_count <= pix_count + 1'b1;
          end
        end
      end else if (frame_sync) begin
        buf_sel <= ~buf_sel;
        state   <= FB_WRITE;
      end
    end
  end

endmodule
